// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   - FSM state encoding (IDLE / BUSY_IF / BUSY_D)
//   - grant encoding (FETCH = 0, DATA = 1)
//   - default address/data widths used by the processor datapath
//   - counter width helper for the timeout counter
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // Width needed to count 0..timeout, never less than one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Timeout counter for one memory transaction.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - load the count with zero (transaction start)
//   enable    - advance the count by one (cycle waited without ready)
//   expired   - high when the count reached TIMEOUT-1; never high when TIMEOUT == 0
module mem_arb_timeout
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT != 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            // With the timeout disabled the count simply wraps; it is unused.
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory between the instruction-fetch path and
// the load/store path. One transaction at a time, round-robin on contention,
// variable-latency ready with an optional timeout that error-acks the
// requester and sets a sticky bus_err.
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   if_req/if_addr                    - fetch request (level, held until ack)
//   if_rdata/if_ack/if_err            - fetch response (ack one cycle, err qualifies ack)
//   d_req/d_we/d_addr/d_wdata         - load/store request (level, held until ack)
//   d_rdata/d_ack/d_err               - load/store response
//   mem_req/mem_we/mem_addr/mem_wdata - memory transaction, held stable while mem_req
//   mem_rdata/mem_ready               - memory completion and read data
//   bus_err                           - sticky timeout flag, cleared only by rst
// All outputs are registered.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    arb_state_t        state, state_nxt;
    grant_t            last_grant, last_grant_nxt;

    logic              mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, d_rdata_nxt;
    logic              if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt;
    logic              bus_err_nxt;

    logic              if_elig, d_elig, pick_d;
    logic              cnt_clear, cnt_en, expired;

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        if_rdata_nxt   = if_rdata;
        d_rdata_nxt    = d_rdata;
        if_ack_nxt     = 1'b0;
        if_err_nxt     = 1'b0;
        d_ack_nxt      = 1'b0;
        d_err_nxt      = 1'b0;
        bus_err_nxt    = bus_err;
        cnt_clear      = 1'b0;
        cnt_en         = 1'b0;

        // A requester still holds req during its ack cycle; masking with the
        // registered ack stops it from being granted a second time.
        if_elig = if_req && !if_ack;
        d_elig  = d_req && !d_ack;
        pick_d  = d_elig && (!if_elig || (last_grant == FETCH));

        case (state)
            IDLE: begin
                if (pick_d) begin
                    mem_req_nxt    = 1'b1;
                    mem_we_nxt     = d_we;
                    mem_addr_nxt   = d_addr;
                    mem_wdata_nxt  = d_wdata;
                    cnt_clear      = 1'b1;
                    last_grant_nxt = DATA;
                    state_nxt      = BUSY_D;
                end else if (if_elig) begin
                    mem_req_nxt    = 1'b1;
                    mem_we_nxt     = 1'b0;
                    mem_addr_nxt   = if_addr;
                    mem_wdata_nxt  = '0;
                    cnt_clear      = 1'b1;
                    last_grant_nxt = FETCH;
                    state_nxt      = BUSY_IF;
                end
            end

            BUSY_IF, BUSY_D: begin
                if (mem_ready) begin
                    if (state == BUSY_IF) begin
                        if_rdata_nxt = mem_rdata;
                        if_ack_nxt   = 1'b1;
                    end else begin
                        // Stores leave the load-data register untouched.
                        if (!mem_we) d_rdata_nxt = mem_rdata;
                        d_ack_nxt = 1'b1;
                    end
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    state_nxt   = IDLE;
                end else if (expired) begin
                    if (state == BUSY_IF) begin
                        if_rdata_nxt = '0;
                        if_ack_nxt   = 1'b1;
                        if_err_nxt   = 1'b1;
                    end else begin
                        d_rdata_nxt = '0;
                        d_ack_nxt   = 1'b1;
                        d_err_nxt   = 1'b1;
                    end
                    bus_err_nxt = 1'b1;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: begin
                mem_req_nxt = 1'b0;
                mem_we_nxt  = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops mem_req at once with no ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= FETCH;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            if_err     <= 1'b0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            if_rdata   <= if_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            if_ack     <= if_ack_nxt;
            if_err     <= if_err_nxt;
            d_ack      <= d_ack_nxt;
            d_err      <= d_err_nxt;
            bus_err    <= bus_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT = 4): a table of single
// transactions plus hand-written sequences for ack masking, reset abort and
// round-robin contention.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ack, if_err;
    logic        d_req, d_we;
    logic [15:0] d_addr, d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack, d_err;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;        // memory answer
        int          delay;        // mem_req cycle in which ready is given, 0 = never
        logic [15:0] exp_if_rdata;
        logic [15:0] exp_d_rdata;
        logic        exp_err;
        int          exp_cycles;   // cycles mem_req stays high
        logic        exp_bus_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Wait (bounded) at negedges for mem_req; n = negedges waited.
    task automatic wait_grant(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   n;
        int   cyc;
        logic stable;
        logic [15:0] exp_wd;
        exp_wd = v.is_d ? v.wdata : 16'h0000;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        wait_grant(n);
        check($sformatf("v%0d_latency", idx), n, 1);
        check($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
        check($sformatf("v%0d_mem_we", idx), mem_we, v.is_d ? v.we : 1'b0);
        check($sformatf("v%0d_mem_wdata", idx), mem_wdata, exp_wd);
        cyc = 0;
        stable = 1'b1;
        while (mem_req && cyc < 40) begin
            cyc++;
            if (mem_addr !== v.addr || mem_wdata !== exp_wd) stable = 1'b0;
            mem_ready = (v.delay != 0 && cyc == v.delay);
            mem_rdata = mem_ready ? v.rdata : 16'hDEAD;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check($sformatf("v%0d_cycles", idx), cyc, v.exp_cycles);
        check($sformatf("v%0d_stable", idx), stable, 1'b1);
        check($sformatf("v%0d_ack", idx), {if_ack, d_ack}, v.is_d ? 2'b01 : 2'b10);
        check($sformatf("v%0d_err", idx), {if_err, d_err},
              v.exp_err ? (v.is_d ? 2'b01 : 2'b10) : 2'b00);
        check($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp_if_rdata);
        check($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_d_rdata);
        check($sformatf("v%0d_bus_err", idx), bus_err, v.exp_bus_err);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_ack_width", idx), {if_ack, d_ack, if_err, d_err}, 4'b0000);
    endtask

    initial begin
        int n;
        int dcnt;
        int fcnt;
        logic got_d;
        logic exp_d_order[6];

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        //               is_d we  addr      wdata     rdata     dly  if_rd     d_rd      err cyc be
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5C3, 3, 16'hA5C3, 16'h0000, 1'b0, 3, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0040, 16'hCAFE, 16'h5A5A, 1, 16'hA5C3, 16'h5A5A, 1'b0, 1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'hFFFF, 1, 16'hA5C3, 16'h5A5A, 1'b0, 1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0F0F, 2, 16'h0F0F, 16'h5A5A, 1'b0, 2, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 16'h0000, 0, 16'h0F0F, 16'h0000, 1'b1, 4, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 4, 16'hBEEF, 16'h0000, 1'b0, 4, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 16'h1357, 2, 16'hBEEF, 16'h1357, 1'b0, 2, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 16'h0400, 16'h7777, 16'h0000, 0, 16'hBEEF, 16'h0000, 1'b1, 4, 1'b1};

        // Reset state.
        @(negedge clk);
        check("rst_rdata", {if_rdata, d_rdata}, 32'h0);
        check("rst_mem_bus", {mem_addr, mem_wdata}, 32'h0);
        check("rst_ctrl", {if_ack, if_err, d_ack, d_err, mem_req, mem_we, bus_err}, 7'h0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Ack masking: req held exactly through the ack cycle; stray ready in IDLE.
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0A0A;
        wait_grant(n);
        check("mask_grant", mem_req, 1'b1);
        mem_ready = 1'b1; mem_rdata = 16'h4444;
        @(negedge clk);
        mem_ready = 1'b0;
        check("mask_ack", {if_ack, if_rdata}, {1'b1, 16'h4444});
        @(posedge clk);
        #1 if_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'h9999;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mask_idle%0d", k), {mem_req, if_ack, d_ack}, 3'b000);
        end
        mem_ready = 1'b0;
        check("mask_rdata_hold", if_rdata, 16'h4444);

        // Reset in the middle of a fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0777;
        wait_grant(n);
        check("abort_busy", mem_req, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_flags", {if_ack, if_err, bus_err}, 3'b000);
        @(negedge clk);
        check("abort_no_ack", {if_ack, mem_req}, 2'b00);
        rst = 1'b0;
        wait_grant(n);
        check("regrant_latency", n, 1);
        check("regrant_addr", mem_addr, 16'h0777);
        mem_ready = 1'b1; mem_rdata = 16'h6161;
        @(negedge clk);
        mem_ready = 1'b0;
        if_req = 1'b0;
        check("regrant_ack", {if_ack, if_err, if_rdata}, {2'b10, 16'h6161});

        // Contention right after reset: DATA wins the first tie, then alternation.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_d_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        if_addr = 16'h0100; d_addr = 16'h0300; d_we = 1'b0; d_wdata = 16'h0000;
        if_req = 1'b1; d_req = 1'b1;
        dcnt = 0; fcnt = 0;
        for (int t = 0; t < 6; t++) begin
            wait_grant(n);
            check($sformatf("cont%0d_gap", t), n, 1);
            got_d = (mem_addr == 16'h0300);
            check($sformatf("cont%0d_grant", t), got_d, exp_d_order[t]);
            mem_ready = 1'b1; mem_rdata = 16'h1000 + 16'(t);
            @(negedge clk);
            mem_ready = 1'b0;
            check($sformatf("cont%0d_acks", t), {if_ack, d_ack}, got_d ? 2'b01 : 2'b10);
            if (got_d) begin
                check($sformatf("cont%0d_rdata", t), d_rdata, 16'h1000 + 16'(t));
                dcnt++;
                if (dcnt == 3) d_req = 1'b0;
            end else begin
                check($sformatf("cont%0d_rdata", t), if_rdata, 16'h1000 + 16'(t));
                fcnt++;
                if (fcnt == 3) if_req = 1'b0;
            end
        end
        @(negedge clk);
        check("cont_done", {mem_req, if_ack, d_ack}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified 16-bit memory between two requesters: the instruction-fetch path and the load/store data path of the multicycle controller.
- Grants one requester at a time, with round-robin priority on contention.
- Drives one memory transaction at a time, waiting for a variable-latency ready.
- Returns read data with an ack, or an error ack on timeout.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum cycles to wait for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data.
- if_ack  out  1  one-cycle completion pulse.
- if_err  out  1  qualifies if_ack; high on timeout.
- d_req  in  1  data request, level; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  qualifies d_ack; high on timeout.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  write strobe, valid while mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready.
- mem_ready  in  1  memory completion.
- bus_err  out  1  sticky: set by any timeout, cleared only by rst.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; all outputs = 0; last_grant = FETCH, so data wins the first tie.
  - A reset asserted mid-transaction drops mem_req immediately. No ack is issued for the aborted transaction.
- States: IDLE, BUSY_IF, BUSY_D. All outputs are registered.
- IDLE:
  - A requester is eligible if its req = 1 and its ack is not high this cycle. This masks the ack cycle, during which the requester still holds req.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On the grant edge:
    - latch addr, we and wdata into the mem_* registers; fetch forces mem_we = 0 and mem_wdata = 0;
    - set mem_req = 1 and load timeout counter = 0;
    - update last_grant and go to BUSY_IF or BUSY_D.
- Latency: req sampled high at edge N gives mem_req high in cycle N+1. The minimum transaction is a grant edge, a ready edge, then the ack cycle.
- BUSY_x, at each edge:
  - mem_ready = 1:
    - capture mem_rdata into x_rdata (loads and fetches only; x_rdata unchanged on stores);
    - pulse x_ack = 1 with x_err = 0;
    - mem_req = 0, mem_we = 0; go to IDLE.
  - mem_ready = 0 and TIMEOUT != 0 and counter == TIMEOUT-1:
    - x_ack = 1, x_err = 1, x_rdata = 0;
    - bus_err = 1; mem_req = 0; go to IDLE.
  - Otherwise: increment counter; mem_addr, mem_we and mem_wdata stay stable.
- Requester changes: req/addr changes during BUSY are ignored, because addresses are latched.
- Back-to-back: a new grant can occur at the edge ending the ack cycle, since the ack mask lasts one cycle. The minimum gap between two mem_req pulses is 1 idle cycle.
- x_rdata holds its value until the next ack on that port.
- x_ack and x_err are exactly one cycle wide. if_ack and d_ack are never high together.
- mem_ready while in IDLE is ignored.
- Counter width: clog2(TIMEOUT+1), minimum 1.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE/BUSY_IF/BUSY_D);
  - the grant encoding (FETCH = 0, DATA = 1);
  - the ADDR_W/DATA_W defaults used by the processor datapath.
- One natural sub-module: mem_arb_timeout. It is a loadable counter with inputs clear and enable, and output expired = (TIMEOUT != 0 and count == TIMEOUT-1). It resets asynchronously on rst.
- The rest (arbitration, FSM, output registers) stays in mem_port_arbiter.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x0010; memory answers ready after 3 cycles with 0xA5C3 -> mem_req high 3 cycles, mem_we = 0, mem_addr = 0x0010, if_rdata = 0xA5C3, if_ack one cycle, if_err = 0.
- Single store: d_req = 1, d_we = 1, d_addr = 0x0200, d_wdata = 0x1234; ready on the first cycle -> mem_we = 1, mem_wdata = 0x1234, d_ack pulse; d_rdata unchanged.
- Contention after reset: if_req and d_req asserted together and held through 3 transactions each -> grants go DATA, FETCH, DATA, FETCH, DATA, FETCH; never two acks in one cycle.
- Timeout: TIMEOUT = 4, d_req load, mem_ready held 0 -> d_ack and d_err high in the 5th cycle after the grant edge, d_rdata = 0, bus_err = 1 and staying 1; a later fetch completes normally with if_err = 0.
- Reset mid-transaction: assert rst during BUSY_IF between edges -> mem_req falls without waiting for an edge; no ack; after release the fetch (req still high) is re-granted from IDLE.
- Ack masking: requester keeps req high exactly through the ack cycle -> no duplicate grant; mem_req low for at least 1 cycle between transactions.
